// File: rtl/dm_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// FSM states, byte-lane constants and the request legality check.
package dm_pkg;

    localparam int DW        = 32;
    localparam int LANE_W    = 8;
    localparam int NUM_LANES = DW / LANE_W;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        CAPT = 2'b10,
        WR   = 2'b11
    } state_e;

    // Byte-enable patterns for the lanes a store touches
    localparam logic [NUM_LANES-1:0] BE_BYTE0   = 4'b0001;
    localparam logic [NUM_LANES-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [NUM_LANES-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [NUM_LANES-1:0] BE_WORD    = 4'b1111;

    // Misaligned half/word or reserved size is rejected without touching memory
    function automatic logic dm_req_err(logic [1:0] sz, logic [1:0] off);
        logic e;
        case (sz)
            SZ_BYTE: e = 1'b0;
            SZ_HALF: e = off[0];
            SZ_WORD: e = (off != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Pipeline-side request/completion bus and the data-memory port bus.
interface dm_req_if #(parameter int AW = 32);
    logic          REQ;
    logic          WE;
    logic [1:0]    SIZE;
    logic          SIGNED;
    logic [AW-1:0] ADDR;
    logic [31:0]   WDATA;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic [31:0]   RDATA;

    modport master (output REQ, WE, SIZE, SIGNED, ADDR, WDATA,
                    input  BUSY, DONE, ERR, RDATA);
    modport slave  (input  REQ, WE, SIZE, SIGNED, ADDR, WDATA,
                    output BUSY, DONE, ERR, RDATA);
endinterface

interface dm_mem_if;
    logic        W_DM;
    logic [31:0] AD;
    logic [31:0] WP;
    logic [31:0] PR;

    modport master (output W_DM, AD, WP, input PR);
    modport slave  (input W_DM, AD, WP, output PR);
endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering: extracts and extends the load lane from the read
// word, and merges right-justified store data into the read word.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [DW-1:0] pr,
    input  logic [DW-1:0] wdata,
    input  logic [1:0]    off,
    input  size_e         size,
    input  logic          sgn,
    output logic [DW-1:0] ld_val,
    output logic [DW-1:0] st_word
);
    logic [LANE_W-1:0]    b;
    logic [15:0]          h;
    logic [NUM_LANES-1:0] be;
    logic [DW-1:0]        wsrc;

    // Lane select, extension, and replication of store data onto every lane
    always_comb begin
        b    = pr[{off, 3'b000} +: LANE_W];
        h    = off[1] ? pr[31:16] : pr[15:0];
        case (size)
            SZ_BYTE: begin
                ld_val = {{24{sgn & b[7]}}, b};
                be     = BE_BYTE0 << off;
                wsrc   = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                ld_val = {{16{sgn & h[15]}}, h};
                be     = off[1] ? BE_HALF_HI : BE_HALF_LO;
                wsrc   = {2{wdata[15:0]}};
            end
            default: begin
                ld_val = pr;
                be     = BE_WORD;
                wsrc   = wdata;
            end
        endcase
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign st_word[k*LANE_W +: LANE_W] = be[k] ? wsrc[k*LANE_W +: LANE_W]
                                                   : pr[k*LANE_W +: LANE_W];
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory initiator: latches a load/store request, sequences the
// read / capture / write cycles against a registered-read memory, and
// reports completion with a one-cycle DONE (plus ERR for bad requests).
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic     CLK,
    input  logic     RST_N,
    dm_req_if.slave  req,
    dm_mem_if.master mem
);
    state_e        state_q, state_d;
    logic          we_q, sgn_q;
    size_e         size_q;
    logic [1:0]    off_q;
    logic [DW-1:0] wdata_q, merge_q, rdata_q, ad_q;
    logic          done_q, err_q;
    logic [DW-1:0] ld_val, st_word;
    logic          accept, bad_req;

    assign accept  = (state_q == IDLE) && req.REQ;
    assign bad_req = dm_req_err(req.SIZE, req.ADDR[1:0]);

    dm_lane_align u_align (
        .pr      (mem.PR),
        .wdata   (wdata_q),
        .off     (off_q),
        .size    (size_q),
        .sgn     (sgn_q),
        .ld_val  (ld_val),
        .st_word (st_word)
    );

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: word stores skip the read; sub-word stores read first
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !bad_req)
                      state_d = (req.WE && req.SIZE == SZ_WORD) ? WR : RD;
            RD:   state_d = CAPT;
            CAPT: state_d = we_q ? WR : IDLE;
            WR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; W_DM follows the state so reset kills it at once
    always_comb begin
        req.BUSY = (state_q != IDLE);
        mem.W_DM = (state_q == WR);
        mem.WP   = (state_q == WR && size_q == SZ_WORD) ? wdata_q : merge_q;
    end

    // Request latch; the word address is only updated for legal requests
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            we_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            off_q   <= 2'b00;
            wdata_q <= '0;
            ad_q    <= '0;
        end else if (accept) begin
            we_q    <= req.WE;
            sgn_q   <= req.SIGNED;
            size_q  <= size_e'(req.SIZE);
            off_q   <= req.ADDR[1:0];
            wdata_q <= req.WDATA;
            if (!bad_req) ad_q <= DW'(req.ADDR[AW-1:2]);
        end
    end

    // Capture of read data: load result or read-modify-write merge word
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rdata_q <= '0;
            merge_q <= '0;
        end else if (state_q == CAPT) begin
            if (we_q) merge_q <= st_word;
            else      rdata_q <= ld_val;
        end
    end

    // Completion pulse, raised on the edge the FSM returns to IDLE
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (accept && bad_req) || (state_q == CAPT && !we_q) || (state_q == WR);
            err_q  <= accept && bad_req;
        end
    end

    assign req.DONE  = done_q;
    assign req.ERR   = err_q;
    assign req.RDATA = rdata_q;
    assign mem.AD    = ad_q;

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Initiator side of the processor's data-memory port. Takes load/store requests from the execute/memory stage through a REQ/DONE handshake and turns them into data-memory transactions on W_DM/AD/WP/PR. Supports byte, half-word and word accesses. Sub-word stores use read-modify-write, and loads are sign- or zero-extended. It sits between the pipeline's memory stage and `data_memory`, which writes synchronously and returns read data registered, one cycle after the address.

## Interface
- AW, 32, byte-address width of ADDR
- DW, 32, data width; fixed at 32 (four byte lanes)
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- REQ  in  1  request strobe; sampled only in IDLE
- WE  in  1  1 = store, 0 = load
- SIZE  in  2  00 byte, 01 half, 10 word, 11 reserved
- SIGNED  in  1  load extension: 1 = sign-extend, 0 = zero-extend
- ADDR  in  AW  byte address
- WDATA  in  32  store data, right-justified
- BUSY  out  1  high whenever the FSM is not in IDLE
- DONE  out  1  one-cycle completion pulse
- ERR  out  1  valid with DONE: misaligned address or reserved SIZE
- RDATA  out  32  extended load result; holds its value until the next load completes
- W_DM  out  1  memory write enable
- AD  out  32  memory word address = {2'b00, ADDR[AW-1:2]}
- WP  out  32  memory write data
- PR  in  32  memory read data, valid one cycle after AD is presented with W_DM=0

## Operation
- Request latch: at the edge where IDLE and REQ=1, latch WE, SIZE, SIGNED, ADDR and WDATA. REQ is ignored in every other state.
- Errors: a half access with ADDR[0]=1, a word access with ADDR[1:0]≠0, or SIZE=11.
  - Set ERR=1 and DONE=1 on the next cycle.
  - No memory access is made; FSM stays in IDLE.
- States and transitions:
  - IDLE: accept a request. Word store goes to WR. Load or sub-word store goes to RD. An erroneous request stays in IDLE.
  - RD: drive AD; W_DM=0. Go to CAPT.
  - CAPT: PR is valid.
    - Load: RDATA ← extended lane, DONE=1, go to IDLE.
    - Sub-word store: merge register ← PR with the target lane replaced by WDATA, go to WR.
  - WR: W_DM=1; WP = WDATA (word store) or the merge register. DONE=1, go to IDLE.
- Byte lanes are little-endian.
  - Byte: lane ADDR[1:0], bits [8k+7:8k].
  - Half: ADDR[1] selects [15:0] or [31:16].
- Extension:
  - Byte: bit 7 replicated (SIGNED=1) or zeros.
  - Half: bit 15 replicated (SIGNED=1) or zeros.
  - Word: SIGNED is ignored.
- W_DM=1 only in WR.
- AD is driven from the latched address in RD, CAPT and WR, and holds its last value otherwise.
- WP equals the merge register outside WR.

## Timing
- Reset values: FSM=IDLE; BUSY, DONE, ERR, W_DM all 0; RDATA, AD, WP and merge register 0x00000000.
- Latency from the accepting edge E0 to the DONE-high cycle:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- DONE and ERR are registered and high for exactly one cycle. DONE is asserted in the cycle the FSM returns to IDLE, so BUSY=0 during DONE.
- Back-to-back requests: a REQ present during the DONE cycle is accepted at that edge, with no bubble.
- Reset mid-operation: W_DM drops immediately, the FSM goes to IDLE and no write occurs, even during WR. The memory word keeps its prior value.
- WDATA, ADDR and the other request inputs may change after E0; only the latched copies are used.

## Structure
- `dm_pkg`:
  - SIZE encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - FSM state encoding (IDLE, RD, CAPT, WR)
  - lane-select helper constants
- Sub-module `dm_lane_align` (combinational), instantiated once. Inputs: PR, WDATA, offset, SIZE, SIGNED. Outputs: the extended load value and the merged store word.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load 0x10: store DONE 2 cycles after E0; load DONE 3 cycles after E0 with RDATA=0xDEADBEEF; W_DM high exactly one cycle.
- Byte store 0xA5 to 0x11, then loads:
  - word load 0x10 → 0xDEADA5EF
  - signed byte load 0x11 → 0xFFFFFFA5
  - unsigned byte load 0x11 → 0x000000A5
  - byte store DONE 4 cycles after E0
- Half store 0x8001 to 0x12, then loads:
  - word load 0x10 → 0x8001A5EF
  - signed half load 0x12 → 0xFFFF8001
  - unsigned half load 0x12 → 0x00008001
- Word load at 0x06, half store at 0x03, and SIZE=11: each gives ERR=1 and DONE=1 one cycle after E0; W_DM never asserted; RDATA unchanged.
- REQ held high through a load: exactly one transaction while BUSY. A second request presented in the DONE cycle is accepted with no idle cycle.
- RST_N low during the WR cycle of a byte store to 0x10: W_DM falls asynchronously; all outputs return to 0; a later word load 0x10 returns the pre-store value.
